// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC scan sequencer: FSM state encoding, the
// fixed fields of the SPI command word, bus widths and the default number of
// scanned ADCs. Also holds small helpers used by the sequencer.
// ---------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int unsigned N_ADC_DEFAULT = 5;
    localparam int unsigned SEL_W         = 3;
    localparam int unsigned DATA_W        = 16;

    // Fixed fields of the MOSI command word
    localparam logic [3:0] CMD_PREFIX       = 4'b0001;
    localparam logic       CMD_SINGLE_ENDED = 1'b1;
    localparam logic [6:0] CMD_TAIL         = 7'b1000000;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitFin,
        StStore,
        StNext
    } seq_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] first_set(input logic [7:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [DATA_W-1:0] build_cmd(input logic [1:0] ch);
        return {CMD_PREFIX, CMD_SINGLE_ENDED, 2'b00, ch, CMD_TAIL};
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer_if
// Groups the sequencer's SPI-master handshake and FIFO write port.
//   spi_ena   : enable to the shared SPI master
//   spi_cmd   : MOSI command word
//   spi_sel   : index of the ADC routed to the SPI master
//   spi_fin   : SPI master finished flag (level)
//   spi_data  : MISO word
//   fifo_wr   : one-cycle write strobe
//   fifo_din  : {spi_sel, spi_data}
//   fifo_full : downstream FIFO full
// master = sequencer side, slave = SPI master / FIFO side.
// ---------------------------------------------------------------------------
interface adc_scan_sequencer_if;
    import adc_seq_pkg::*;

    logic                    spi_ena;
    logic [DATA_W-1:0]       spi_cmd;
    logic [SEL_W-1:0]        spi_sel;
    logic                    spi_fin;
    logic [DATA_W-1:0]       spi_data;
    logic                    fifo_wr;
    logic [SEL_W+DATA_W-1:0] fifo_din;
    logic                    fifo_full;

    modport master (
        output spi_ena, spi_cmd, spi_sel, fifo_wr, fifo_din,
        input  spi_fin, spi_data, fifo_full
    );

    modport slave (
        input  spi_ena, spi_cmd, spi_sel, fifo_wr, fifo_din,
        output spi_fin, spi_data, fifo_full
    );

endinterface

// File: rtl/adc_seq_next_sel.sv
// ---------------------------------------------------------------------------
// adc_seq_next_sel
// Priority search for the next set mask bit strictly above the current index.
//   i_mask  : latched channel mask
//   i_cur   : index of the ADC just converted
//   o_next  : lowest set bit index greater than i_cur
//   o_valid : high when such a bit exists
// ---------------------------------------------------------------------------
module adc_seq_next_sel
    import adc_seq_pkg::*;
#(
    parameter int unsigned N_ADC = N_ADC_DEFAULT
) (
    input  logic [N_ADC-1:0] i_mask,
    input  logic [SEL_W-1:0] i_cur,
    output logic [SEL_W-1:0] o_next,
    output logic             o_valid
);

    // Descending scan so the lowest qualifying index is the last one written
    always_comb begin
        o_next  = '0;
        o_valid = 1'b0;
        for (int i = N_ADC - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_cur))) begin
                o_next  = SEL_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
// Periodically scans a set of ADCs through a shared SPI master and pushes
// each result into a FIFO as {adc index, data}.
//   i_sys_clk     : sole clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_enable      : permits new scans (a running scan always completes)
//   i_period      : sample period minus one, in clock cycles
//   i_ch_mask     : ADCs included in a scan
//   i_adc_ch      : input-channel field of every command
//   i_clr         : one-cycle pulse clearing sticky flags and drop counter
//   o_busy        : FSM not idle
//   o_overrun     : sticky, period tick arrived during a scan
//   o_timeout_err : sticky, a conversion timed out
//   o_drop_cnt    : samples dropped on FIFO full, saturating
//   bus           : SPI handshake and FIFO write port
// ---------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned N_ADC   = N_ADC_DEFAULT,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        i_sys_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [15:0]                 i_period,
    input  logic [N_ADC-1:0]            i_ch_mask,
    input  logic [1:0]                  i_adc_ch,
    input  logic                        i_clr,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic                        o_timeout_err,
    output logic [7:0]                  o_drop_cnt,
    adc_scan_sequencer_if.master        bus
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_e              r_state;
    seq_state_e              w_state_nxt;
    logic [15:0]             r_period_cnt;
    logic                    w_tick;
    logic                    r_fin_q;
    logic                    r_fin_prev;
    logic                    w_fin_rise;
    logic [N_ADC-1:0]        r_mask;
    logic [1:0]              r_adc_ch;
    logic [SEL_W-1:0]        r_sel;
    logic [SEL_W-1:0]        w_next_sel;
    logic                    w_next_valid;
    logic [TW-1:0]           r_wait_cnt;
    logic                    w_wait_done;
    logic                    w_start_scan;
    logic                    w_set_ovr;
    logic                    w_set_to;
    logic                    w_store_ok;
    logic                    w_drop;
    logic                    r_fifo_wr;
    logic [SEL_W+DATA_W-1:0] r_fifo_din;
    logic                    r_overrun;
    logic                    r_timeout_err;
    logic [7:0]              r_drop_cnt;

    adc_seq_next_sel #(
        .N_ADC (N_ADC)
    ) u_next_sel (
        .i_mask  (r_mask),
        .i_cur   (r_sel),
        .o_next  (w_next_sel),
        .o_valid (w_next_valid)
    );

    assign w_tick      = (r_period_cnt == i_period);
    assign w_fin_rise  = r_fin_q & ~r_fin_prev;
    assign w_wait_done = (r_wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_start_scan = 1'b0;
        w_set_to     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_tick && i_enable && (|i_ch_mask)) begin
                    w_state_nxt  = StStart;
                    w_start_scan = 1'b1;
                end
            end
            StStart:   w_state_nxt = StWaitFin;
            StWaitFin: begin
                if (w_fin_rise) begin
                    w_state_nxt = StStore;
                end else if (w_wait_done) begin
                    w_state_nxt = StNext;
                    w_set_to    = 1'b1;
                end
            end
            StStore:   w_state_nxt = StNext;
            StNext:    w_state_nxt = w_next_valid ? StStart : StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    // Ticks during a scan are only recorded; they never restart it
    assign w_set_ovr  = w_tick && (r_state != StIdle);
    assign w_store_ok = (r_state == StStore) && !bus.fifo_full;
    assign w_drop     = (r_state == StStore) && bus.fifo_full;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_period_cnt  <= '0;
            r_fin_q       <= 1'b0;
            r_fin_prev    <= 1'b0;
            r_mask        <= '0;
            r_adc_ch      <= '0;
            r_sel         <= '0;
            r_wait_cnt    <= '0;
            r_fifo_wr     <= 1'b0;
            r_fifo_din    <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_period_cnt <= w_tick ? 16'd0 : r_period_cnt + 16'd1;
            r_fin_q      <= bus.spi_fin;
            r_fin_prev   <= r_fin_q;

            if (w_start_scan) begin
                r_mask   <= i_ch_mask;
                r_adc_ch <= i_adc_ch;
                r_sel    <= first_set(8'(i_ch_mask));
            end else if ((r_state == StNext) && w_next_valid) begin
                r_sel <= w_next_sel;
            end

            r_wait_cnt <= (r_state == StWaitFin) ? r_wait_cnt + TW'(1) : '0;

            r_fifo_wr <= w_store_ok;
            if (w_store_ok) begin
                r_fifo_din <= {r_sel, bus.spi_data};
            end

            // Flag-setting events take priority over a coincident clear
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (i_clr) begin
                r_overrun <= 1'b0;
            end

            if (w_set_to) begin
                r_timeout_err <= 1'b1;
            end else if (i_clr) begin
                r_timeout_err <= 1'b0;
            end

            if (w_drop) begin
                if (i_clr) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (i_clr) begin
                r_drop_cnt <= '0;
            end
        end
    end

    assign bus.spi_ena  = (r_state == StStart) || (r_state == StWaitFin);
    assign bus.spi_cmd  = build_cmd(r_adc_ch);
    assign bus.spi_sel  = r_sel;
    assign bus.fifo_wr  = r_fifo_wr;
    assign bus.fifo_din = r_fifo_din;

    assign o_busy        = (r_state != StIdle);
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter N_ADC, default 5: number of ADC chip selects scanned (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 255: max SYS_CLK cycles waited for SPI_FIN per conversion.
REQ-003 SYS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ENABLE  in  1  level; permits new scans.
REQ-006 PERIOD  in  16  sample period minus one, in SYS_CLK cycles.
REQ-007 CH_MASK  in  N_ADC  ADCs included in a scan; bit i = ADC i.
REQ-008 ADC_CH  in  2  input-channel field placed in every command.
REQ-009 CLR  in  1  one-cycle pulse; clears sticky flags and DROP_CNT.
REQ-010 SPI_ENA  out  1  enable to the shared SPI master.
REQ-011 SPI_CMD  out  16  MOSI word = {4'b0001, 1'b1, 2'b00, ADC_CH, 7'b1000000}.
REQ-012 SPI_SEL  out  3  index of ADC currently routed to the SPI master.
REQ-013 SPI_FIN  in  1  SPI master finished flag (level; rising edge is significant).
REQ-014 SPI_DATA  in  16  MISO word from the SPI master.
REQ-015 FIFO_WR  out  1  one-cycle write strobe.
REQ-016 FIFO_DIN  out  19  {SPI_SEL, SPI_DATA}.
REQ-017 FIFO_FULL  in  1  downstream FIFO full.
REQ-018 BUSY  out  1  high whenever state is not IDLE.
REQ-019 OVERRUN  out  1  sticky: period tick arrived during a scan.
REQ-020 TIMEOUT_ERR  out  1  sticky: conversion timed out.
REQ-021 DROP_CNT  out  8  samples dropped on FIFO_FULL, saturating at 255.

Function
REQ-022 Period counter SHALL count 0..PERIOD, emit one-cycle tick on reaching PERIOD, and reload 0 the next cycle; it SHALL run regardless of ENABLE.
REQ-023 PERIOD=0 SHALL produce a tick every cycle.
REQ-024 FSM states SHALL be IDLE, START, WAIT_FIN, STORE, NEXT.
REQ-025 IDLE->START on tick when ENABLE=1 and CH_MASK!=0; CH_MASK and ADC_CH SHALL be latched then, and SPI_SEL set to the lowest set bit.
REQ-026 Tick with ENABLE=0 or CH_MASK=0 SHALL be ignored without setting flags.
REQ-027 START SHALL last one cycle; SPI_ENA SHALL rise the cycle after the tick and stay high through WAIT_FIN.
REQ-028 SPI_FIN SHALL be registered once; its rising edge (registered=1, previous=0) in WAIT_FIN SHALL move to STORE and drop SPI_ENA the same transition.
REQ-029 In STORE with FIFO_FULL=0, FIFO_WR SHALL pulse for exactly one cycle with FIFO_DIN valid; FIFO_WR asserts two cycles after SPI_FIN is first sampled high.
REQ-030 In STORE with FIFO_FULL=1, no write SHALL occur and DROP_CNT SHALL increment, saturating at 255.
REQ-031 WAIT_FIN lasting TIMEOUT cycles without a FIN edge SHALL set TIMEOUT_ERR, drop SPI_ENA, skip STORE, go to NEXT.
REQ-032 NEXT SHALL select the next higher set bit of the latched mask and go to START; if none, go to IDLE.
REQ-033 Tick while BUSY SHALL set OVERRUN and SHALL NOT restart or extend the scan.
REQ-034 ENABLE deassert mid-scan SHALL let the current scan complete.
REQ-035 CLR coinciding with a flag-setting event SHALL leave the flag set (set wins).
REQ-036 SPI_SEL and SPI_CMD SHALL remain stable from START through STORE.

Reset
REQ-037 On reset: state IDLE, period counter 0, SPI_ENA 0, SPI_SEL 0, FIFO_WR 0, FIFO_DIN 0, BUSY 0, OVERRUN 0, TIMEOUT_ERR 0, DROP_CNT 0, FIN history 0.
REQ-038 Reset mid-conversion SHALL drop SPI_ENA in the next cycle and discard the pending sample.

Structure
REQ-039 Shared package adc_seq_pkg SHALL hold the state enum, the command-field constants (prefix 4'b0001, single-ended bit, 7'b1000000 tail), and the N_ADC default.
REQ-040 Next-set-bit priority search SHALL be a sub-module adc_seq_next_sel (inputs: mask, current index; outputs: next index, valid).

Verification
REQ-041 PERIOD=99, CH_MASK=5'b10101, FIN model 20 cycles -> three writes per tick, FIFO_DIN[18:16]=0,2,4 in order, BUSY low before the next tick.
REQ-042 FIFO_FULL held high for one scan of mask 5'b00011 -> no FIFO_WR, DROP_CNT=2; 300 such drops -> DROP_CNT=255.
REQ-043 FIN never asserted, TIMEOUT=255 -> SPI_ENA low after 255 cycles, TIMEOUT_ERR=1, scan advances to next ADC.
REQ-044 PERIOD=10, 5 ADCs, FIN 20 cycles -> OVERRUN=1, scans never overlap; CLR -> OVERRUN=0.
REQ-045 Reset asserted in WAIT_FIN -> next cycle SPI_ENA=0, BUSY=0, no FIFO_WR for the pending sample.
REQ-046 ADC_CH=2'b10 -> SPI_CMD=16'h1940; ADC_CH changed mid-scan -> SPI_CMD unchanged until the next scan.
